// File: rtl/uart_rx_vote_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_vote_sampler
// Description : Mid-bit oversampling sampler for the UART RX path. Captures
//               NUM_SAMPLES oversampled values centred on the bit middle,
//               majority-votes them and flags disagreement between them.
//               Also flags a Prescale that cannot hold the window, and can
//               optionally synchronise the serial input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_vote_sampler #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  S_Data,
    input  logic                  S_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [PRESCALE_W-1:0] edge_count,
    output logic                  sampled,
    output logic                  Sampled_bit,
    output logic                  noise_err,
    output logic                  cfg_err
);

    // Window arithmetic is one bit wider than Prescale so mid+H never wraps.
    localparam int             c_W   = PRESCALE_W + 1;
    localparam int             c_H   = (NUM_SAMPLES - 1) / 2;
    localparam int             c_CW  = 4;
    localparam logic [c_W-1:0] c_H_W = c_W'(c_H);

    generate
        if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > 7) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_num_samples
            $error("uart_rx_vote_sampler: NUM_SAMPLES must be odd and in 1..7");
        end
        if ((SYNC_STAGES < 0) || (SYNC_STAGES > 3)) begin : g_bad_sync_stages
            $error("uart_rx_vote_sampler: SYNC_STAGES must be in 0..3");
        end
    endgenerate

    logic [c_W-1:0]  w_prescale;
    logic [c_W-1:0]  w_edge;
    logic [c_W-1:0]  w_mid;
    logic [c_W-1:0]  w_first;
    logic [c_W-1:0]  w_last;
    logic            w_cfg_bad;
    logic            w_d;
    logic            w_vote_hit;
    logic [c_CW-1:0] w_stored_ones;
    logic [c_CW-1:0] w_ones;

    assign w_prescale = {1'b0, Prescale};
    assign w_edge     = {1'b0, edge_count};
    assign w_mid      = w_prescale >> 1;
    // w_first wraps when mid < H, but that case also raises cfg_err and
    // suppresses every capture, so the wrapped value is never used.
    assign w_first    = w_mid - c_H_W;
    assign w_last     = w_mid + c_H_W;
    assign w_cfg_bad  = (w_mid < c_H_W) | (w_last >= w_prescale);

    // The final sample is taken straight from the line, so it needs no register.
    assign w_vote_hit = S_EN & ~cfg_err & (w_edge == w_last);
    assign w_ones     = w_stored_ones + c_CW'(w_d);

    generate
        if (SYNC_STAGES == 0) begin : g_sync_bypass
            assign w_d = S_Data;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // Shift the serial line through the synchroniser; resets to idle-high.
            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset) begin
                    r_sync <= '1;
                end else begin
                    r_sync[0] <= S_Data;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_d = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    generate
        if (NUM_SAMPLES > 1) begin : g_store
            logic [NUM_SAMPLES-2:0] r_sample;

            // Capture the leading N-1 samples at their window indices; disabling clears them.
            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset) begin
                    r_sample <= '0;
                end else if (!S_EN) begin
                    r_sample <= '0;
                end else if (!cfg_err) begin
                    for (int k = 0; k < NUM_SAMPLES - 1; k++) begin
                        if (w_edge == (w_first + c_W'(k))) begin
                            r_sample[k] <= w_d;
                        end
                    end
                end
            end

            // Count ones among the stored samples.
            always_comb begin
                w_stored_ones = '0;
                for (int k = 0; k < NUM_SAMPLES - 1; k++) begin
                    w_stored_ones = w_stored_ones + c_CW'(r_sample[k]);
                end
            end
        end else begin : g_no_store
            assign w_stored_ones = '0;
        end
    endgenerate

    // Register the window-fit check every cycle.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= w_cfg_bad;
        end
    end

    // Vote at the last window index and pulse sampled for one cycle.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sampled     <= 1'b0;
            Sampled_bit <= 1'b0;
            noise_err   <= 1'b0;
        end else if (!S_EN) begin
            sampled     <= 1'b0;
            Sampled_bit <= 1'b0;
            noise_err   <= 1'b0;
        end else begin
            sampled <= w_vote_hit;
            if (w_vote_hit) begin
                Sampled_bit <= (w_ones > c_CW'(c_H));
                noise_err   <= (w_ones != '0) && (w_ones != c_CW'(NUM_SAMPLES));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_vote_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_vote_sampler
// Description : Self-checking bench for uart_rx_vote_sampler. Three instances
//               (N=3 raw, N=5 synchronised, N=3 synchronised) share the line,
//               Prescale, edge_count and reset; each has its own enable.
//               Expected votes are queued per instance when driven and
//               compared, including the pulse cycle, when the pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_vote_sampler;

    typedef struct packed {
        logic        b;
        logic        n;
        logic [31:0] c;
    } exp_t;

    logic       CLK;
    logic       Reset;
    logic       S_Data;
    logic [5:0] Prescale;
    logic [5:0] edge_count;
    logic       en   [3];
    logic       smp  [3];
    logic       sbit [3];
    logic       nerr [3];
    logic       cerr [3];

    int          checks;
    int          failures;
    logic [31:0] cyc;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];

    uart_rx_vote_sampler #(.PRESCALE_W(6), .NUM_SAMPLES(3), .SYNC_STAGES(0)) dut0 (
        .CLK(CLK), .Reset(Reset), .S_Data(S_Data), .S_EN(en[0]),
        .Prescale(Prescale), .edge_count(edge_count),
        .sampled(smp[0]), .Sampled_bit(sbit[0]), .noise_err(nerr[0]), .cfg_err(cerr[0])
    );

    uart_rx_vote_sampler #(.PRESCALE_W(6), .NUM_SAMPLES(5), .SYNC_STAGES(2)) dut1 (
        .CLK(CLK), .Reset(Reset), .S_Data(S_Data), .S_EN(en[1]),
        .Prescale(Prescale), .edge_count(edge_count),
        .sampled(smp[1]), .Sampled_bit(sbit[1]), .noise_err(nerr[1]), .cfg_err(cerr[1])
    );

    uart_rx_vote_sampler #(.PRESCALE_W(6), .NUM_SAMPLES(3), .SYNC_STAGES(2)) dut2 (
        .CLK(CLK), .Reset(Reset), .S_Data(S_Data), .S_EN(en[2]),
        .Prescale(Prescale), .edge_count(edge_count),
        .sampled(smp[2]), .Sampled_bit(sbit[2]), .noise_err(nerr[2]), .cfg_err(cerr[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = '0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int i, input logic b, input logic n, input logic [31:0] c);
        exp_t e;
        e = '{b: b, n: n, c: c};
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Compare every pulse against the oldest queued expectation.
    task automatic mon(input int i);
        exp_t e;
        if (smp[i] === 1'b1) begin
            if (qsize(i) == 0) begin
                checks++;
                assert (qsize(i) != 0) else begin
                    failures++;
                    $error("FAIL d%0d_pulse: observed=unexpected pulse at cycle %0d expected=no pulse", i, cyc);
                end
            end else begin
                case (i)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                chk($sformatf("d%0d_bit", i),   {31'b0, sbit[i]}, {31'b0, e.b});
                chk($sformatf("d%0d_noise", i), {31'b0, nerr[i]}, {31'b0, e.n});
                chk($sformatf("d%0d_cycle", i), cyc, e.c);
            end
        end
    endtask

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) mon(i);
    end

    // One bit period on instance i; dpat[e] is the value the sampler should see at edge e.
    task automatic run_bit(input int i, input int presc, input logic [15:0] dpat);
        int n, dly, h, mid, first, last, ones;
        n     = (i == 1) ? 5 : 3;
        dly   = (i == 0) ? 0 : 2;
        h     = (n - 1) / 2;
        mid   = presc / 2;
        first = mid - h;
        last  = mid + h;
        ones  = 0;
        for (int j = first; j <= last; j++) ones += int'(dpat[j]);
        for (int e = 0; e < presc; e++) begin
            edge_count = 6'(e);
            S_Data     = (e + dly < presc) ? dpat[e + dly] : 1'b1;
            en[i]      = 1'b1;
            if (e == last) push(i, ones > h, (ones != 0) && (ones != n), cyc + 1);
            step();
        end
    endtask

    initial begin
        logic [15:0] pat;
        checks     = 0;
        failures   = 0;
        Reset      = 1'b1;
        S_Data     = 1'b1;
        Prescale   = 6'd8;
        edge_count = 6'd0;
        for (int i = 0; i < 3; i++) en[i] = 1'b0;
        repeat (3) step();

        // Reset state
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_d%0d_sampled", i), {31'b0, smp[i]},  32'd0);
            chk($sformatf("rst_d%0d_bit", i),     {31'b0, sbit[i]}, 32'd0);
            chk($sformatf("rst_d%0d_noise", i),   {31'b0, nerr[i]}, 32'd0);
            chk($sformatf("rst_d%0d_cfg", i),     {31'b0, cerr[i]}, 32'd0);
        end
        Reset = 1'b0;
        step();

        // N=3 raw: 1,0,1 -> bit 1 with noise
        run_bit(0, 8, 16'h0028);
        chk("hold_d0_bit",   {31'b0, sbit[0]}, 32'd1);
        chk("hold_d0_noise", {31'b0, nerr[0]}, 32'd1);

        // Enable drops mid-window: outputs clear, no pulse
        for (int e = 0; e < 4; e++) begin
            edge_count = 6'(e);
            S_Data     = (e == 3);
            step();
        end
        edge_count = 6'd4;
        S_Data     = 1'b0;
        en[0]      = 1'b0;
        step();
        chk("drop_d0_sampled", {31'b0, smp[0]},  32'd0);
        chk("drop_d0_bit",     {31'b0, sbit[0]}, 32'd0);
        chk("drop_d0_noise",   {31'b0, nerr[0]}, 32'd0);
        for (int e = 5; e < 8; e++) begin
            edge_count = 6'(e);
            step();
        end
        run_bit(0, 8, 16'h0038);

        // Partial window discarded: stale ones must not count in the vote
        edge_count = 6'd3; S_Data = 1'b1; en[0] = 1'b1; step();
        edge_count = 6'd4; step();
        edge_count = 6'd6; en[0] = 1'b0; step();
        edge_count = 6'd5; en[0] = 1'b1;
        push(0, 1'b0, 1'b1, cyc + 1);
        step();
        edge_count = 6'd6; step();
        en[0] = 1'b0;
        step();

        // N=5 synchronised, Prescale=16: quiet zeros, then a mixed window
        Prescale = 6'd16;
        step();
        chk("p16_d1_cfg", {31'b0, cerr[1]}, 32'd0);
        run_bit(1, 16, 16'h0000);
        run_bit(1, 16, 16'h02C0);

        // Window does not fit: no pulses over two bit periods
        Prescale = 6'd4;
        step();
        chk("p4_d1_cfg", {31'b0, cerr[1]}, 32'd1);
        for (int r = 0; r < 2; r++) begin
            for (int e = 0; e < 4; e++) begin
                edge_count = 6'(e); S_Data = 1'b0; en[1] = 1'b1; step();
            end
        end
        Prescale = 6'd3;
        S_Data   = 1'b1;
        step();
        chk("p3_d1_cfg", {31'b0, cerr[1]}, 32'd1);
        for (int r = 0; r < 2; r++) begin
            for (int e = 0; e < 3; e++) begin
                edge_count = 6'(e); S_Data = 1'b1; step();
            end
        end
        Prescale = 6'd5;
        step();
        step();
        chk("p5_d1_cfg", {31'b0, cerr[1]}, 32'd0);
        run_bit(1, 5, 16'h0017);
        en[1] = 1'b0;

        // Synchronised line, 0x55 pattern; transitions sit so that only a
        // two-cycle delay puts all three samples inside one line bit
        Prescale = 6'd8;
        step();
        pat = 16'h5555;
        for (int t = 0; t < 64; t++) begin
            edge_count = 6'(t % 8);
            S_Data     = pat[(t + 4) / 8];
            en[2]      = 1'b1;
            if ((t % 8) == 5) push(2, pat[t / 8], 1'b0, cyc + 1);
            step();
        end

        // Reset mid-window, then check the synchroniser restarts at idle-high
        run_bit(2, 8, 16'h0038);
        for (int e = 0; e < 4; e++) begin
            edge_count = 6'(e); S_Data = 1'b0; step();
        end
        edge_count = 6'd4;
        chk("prerst_d2_bit", {31'b0, sbit[2]}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("midrst_d2_sampled", {31'b0, smp[2]},  32'd0);
        chk("midrst_d2_bit",     {31'b0, sbit[2]}, 32'd0);
        chk("midrst_d2_noise",   {31'b0, nerr[2]}, 32'd0);
        chk("midrst_d2_cfg",     {31'b0, cerr[2]}, 32'd0);
        edge_count = 6'd3;
        S_Data     = 1'b0;
        #1;
        Reset = 1'b0;
        step();
        edge_count = 6'd4; step();
        edge_count = 6'd5;
        push(2, 1'b1, 1'b1, cyc + 1);
        step();
        edge_count = 6'd6; step();
        edge_count = 6'd7; step();
        en[2] = 1'b0;
        step();
        step();

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_pending", i), 32'(qsize(i)), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
